// File: rtl/stream_arb_pkg.sv
// Shared constants and types for the 4:1 round-robin stream arbiter.
// Burst lock is compiled in with the STREAM_ARB_LOCK_EN macro.
package stream_arb_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Observable arbiter state, for checkers and waveform debug.
    typedef struct packed {
        arb_state_t       state;
        logic [SEL_W-1:0] ptr;
        logic [SEL_W-1:0] lock_ch;
    } arb_dbg_t;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: the first valid channel at or after ptr,
// scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
module rr_pick_4
    import stream_arb_pkg::*;
(
    input  logic [N_CH-1:0]  valid,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             found
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arb_4_1.sv
// Four-channel round-robin stream arbiter with a single registered output stage
// carrying the winning word and its 2-bit select. STREAM_ARB_LOCK_EN adds burst lock.
module stream_arb_4_1
    import stream_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
`ifdef STREAM_ARB_LOCK_EN
    input  logic [N_CH-1:0]   in_last,
`endif
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel,
    input  logic              out_ready,
    output arb_dbg_t          dbg
);

    // Handshake: a word moves on a channel in the cycle where its valid and
    // ready are both high; out_* are taken downstream when out_valid && out_ready.

    arb_state_t       state, next_state;
    logic [SEL_W-1:0] ptr, lock_ch, next_lock_ch;
    logic [N_CH-1:0]  pick_valid;
    logic [SEL_W-1:0] winner;
    logic             found;
    logic             load;
    logic             xfer;
    logic             is_last;

    assign load = !out_valid || out_ready;

    // While locked only the owning channel may compete.
    assign pick_valid = (state == LOCK) ? (in_valid & (N_CH'(1) << lock_ch)) : in_valid;

    rr_pick_4 u_pick (
        .valid  (pick_valid),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    assign xfer = load && found;

`ifdef STREAM_ARB_LOCK_EN
    assign is_last = in_last[winner];
`else
    assign is_last = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            lock_ch <= '0;
        end else begin
            state   <= next_state;
            lock_ch <= next_lock_ch;
        end
    end

    always_comb begin
        next_state   = state;
        next_lock_ch = lock_ch;
        if (xfer) begin
            if (is_last) begin
                next_state = ARB;
            end else begin
                next_state   = LOCK;
                next_lock_ch = winner;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready = N_CH'(1) << winner;
        end
    end

    // The pointer only advances on the word that closes a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer && is_last) begin
            ptr <= winner + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[winner*W +: W];
            out_sel   <= winner;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

    assign dbg = '{state: state, ptr: ptr, lock_ch: lock_ch};

endmodule
